bin2bcd_param: RTL
==================

BIN2BCD_PARAM -- requirements
Module: bin2bcd_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, binary input width (2..32).
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits (1..10).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  binary value to convert.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
REQ-011 SHALL have port out_ovf  output  1  value exceeds 10^DIGITS-1.

Function
REQ-012 SHALL use one-hot states IDLE, SHIFT, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, capture in_data, clear digits, bit counter and ovf, go to SHIFT.
REQ-014 SHIFT: each cycle, add 3 to every digit >4, then shift {digits, data} left 1; after exactly DATA_WIDTH shifts go to DONE.
REQ-015 Bit shifted out of top digit in any SHIFT cycle SHALL set sticky ovf; out_bcd then holds the low DIGITS digits (value mod 10^DIGITS).
REQ-016 out_valid SHALL rise on the DATA_WIDTH-th rising edge after the accepting edge and remain high, with out_bcd/out_ovf stable, until out_valid&out_ready.
REQ-017 DONE with out_ready=1: go to IDLE next edge; in_ready=1 from that edge; no same-cycle accept in DONE.
REQ-018 in_ready SHALL be 0 in SHIFT and DONE; in_data changes outside IDLE handshake SHALL be ignored.
REQ-019 out_bcd/out_ovf SHALL hold last result after DONE exit until next DONE entry.
REQ-020 Bit counter width SHALL be $clog2(DATA_WIDTH+1); no counter wrap permitted.

Reset
REQ-021 rst SHALL force IDLE immediately; in_ready=1 once rst deasserts, out_valid=0, out_bcd=0, out_ovf=0, counter=0.
REQ-022 rst mid-SHIFT or mid-DONE SHALL abort the conversion with no result emitted.

Configuration
REQ-023 Macro BIN2BCD_SIGNED_EN defined: in_data is two's complement; magnitude taken at capture; extra output out_sign (1 bit, reset 0) = in_data MSB, held with out_bcd; -2^(DATA_WIDTH-1) converts correctly.
REQ-024 Macro undefined: in_data unsigned, no out_sign port, no negation logic.

Structure
REQ-025 Package bin2bcd_pkg SHALL hold state encodings (IDLE/SHIFT/DONE) and BCD constants (ADD3 threshold 4, add value 3).
REQ-026 Sub-module bcd_digit_step SHALL implement one digit: 4-bit in, carry-in bit, add-3-then-shift, 4-bit out, carry-out; generated DIGITS times.

Verification (DATA_WIDTH=16, DIGITS=5 unless stated)
REQ-027 in_data=0 -> out_bcd=0x00000, out_ovf=0, out_valid 16 edges after accept.
REQ-028 in_data=65535 -> out_bcd=0x65535, out_ovf=0; in_data=12345 with DIGITS=4 -> out_bcd=0x2345, out_ovf=1.
REQ-029 out_ready=0 for 10 cycles after out_valid -> out_valid, out_bcd held; in_ready=0 throughout; accept 1 edge after out_ready.
REQ-030 rst pulsed at shift 8 of in_data=9999 -> out_valid never asserts, in_ready=1 after rst; next word 42 -> 0x00042.
REQ-031 BIN2BCD_SIGNED_EN: in_data=0xFFFF -> out_sign=1, out_bcd=0x00001; 0x8000 -> out_sign=1, out_bcd=0x32768.
REQ-032 Back-to-back stream of 100 random words with random out_ready -> every result matches reference model, none dropped or duplicated.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encodings and BCD correction constants for bin2bcd_param.
package bin2bcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        DONE  = 3'b100
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd4;
    localparam logic [3:0] ADD3_VALUE  = 4'd3;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d > ADD3_THRESH) ? d + ADD3_VALUE : d;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one double-dabble digit -- add-3 correction, then shift in carry_i.
module bcd_digit_step
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       carry_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] adj;

    assign adj     = add3(digit_i);
    assign digit_o = {adj[2:0], carry_i};
    assign carry_o = adj[3];

endmodule

// File: rtl/bin2bcd_param.sv
// bin2bcd_param: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_SIGNED_EN for two's-complement input with a separate out_sign output.
module bin2bcd_param
    import bin2bcd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  out_sign
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mag;
    logic [4*DIGITS-1:0]   dig_q;
    logic [4*DIGITS-1:0]   dig_d;
    logic [CW-1:0]         cnt_q;
    logic                  ovf_q;
    logic [DIGITS:0]       carry;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign carry[0]  = data_q[DATA_WIDTH-1];

    // Carries ripple from units upward; whatever leaves the top digit is lost precision.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_step u_step (
            .digit_i (dig_q[4*i +: 4]),
            .carry_i (carry[i]),
            .digit_o (dig_d[4*i +: 4]),
            .carry_o (carry[i+1])
        );
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q;
    // Unsigned reinterpretation of the negation makes -2^(N-1) yield 2^(N-1).
    assign mag = in_data[DATA_WIDTH-1] ? (~in_data + 1'b1) : in_data;
`else
    assign mag = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            out_bcd  <= '0;
            out_ovf  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q   <= 1'b0;
            out_sign <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= mag;
                        dig_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
                        sign_q  <= in_data[DATA_WIDTH-1];
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig_q  <= dig_d;
                    data_q <= data_q << 1;
                    ovf_q  <= ovf_q | carry[DIGITS];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q  <= DONE;
                        out_bcd  <= dig_d;
                        out_ovf  <= ovf_q | carry[DIGITS];
`ifdef BIN2BCD_SIGNED_EN
                        out_sign <= sign_q;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
